// File: rtl/decod38_seq_pkg.sv
// Shared types and constants for the clocked 3-to-8 one-hot decoder.
package decod38_seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HOLD = 2'd1,
      SCAN = 2'd2
   } state_e;

   localparam logic [7:0] ONEHOT_IDLE  = 8'h00;
   localparam logic [7:0] ONEHOT_FIRST = 8'h01;

   // Scan walk: 8'h80 wraps back to 8'h01.
   function automatic logic [7:0] rotl1(input logic [7:0] v);
      return {v[6:0], v[7]};
   endfunction

endpackage

// File: rtl/decod38_seq_if.sv
// Code-in / one-hot-out handshake bundle for decod38_seq.
interface decod38_seq_if;
   logic [2:0] in;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] out;
   logic       out_valid;
   logic       out_ack;

   modport master (output in, in_valid, out_ack, input in_ready, out, out_valid);
   modport slave  (input in, in_valid, out_ack, output in_ready, out, out_valid);
endinterface

// File: rtl/decod38_comb.sv
// Combinational 3-bit code to 8-bit one-hot decoder; all-zero when disabled.
module decod38_comb (
   input  logic [2:0] code,
   input  logic       en,
   output logic [7:0] onehot
);
   always_comb begin
      onehot = '0;
      if (en) begin
         onehot[code] = 1'b1;
      end
   end
endmodule

// File: rtl/decod38_seq.sv
// Registered 3-to-8 decoder with valid/ack output hold and an auto-scan walker.
module decod38_seq
   import decod38_seq_pkg::*;
#(
   parameter int unsigned SCAN_DIV = 4,
   parameter int unsigned CNT_W    = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             scan,
   decod38_seq_if.slave     bus,
   output logic [2:0]       scan_idx,
   output logic [CNT_W-1:0] xfer_cnt
);

   localparam logic [7:0] DIV_LAST = 8'(SCAN_DIV - 1);

   state_e           state_q, state_d;
   logic [7:0]       out_q, out_d;
   logic             out_valid_q, out_valid_d;
   logic [2:0]       scan_idx_q, scan_idx_d;
   logic [7:0]       div_q, div_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             in_ready;
   logic             accept;
   logic [7:0]       dec_oh;

   decod38_comb u_dec (
      .code   (bus.in),
      .en     (en),
      .onehot (dec_oh)
   );

   // Held low during reset so no transfer is ever reported as accepted then.
   assign in_ready = !rst && en &&
                     ((state_q == IDLE && !scan) || (state_q == HOLD && bus.out_ack));
   assign accept   = bus.in_valid && in_ready;

   always_comb begin
      state_d     = state_q;
      out_d       = out_q;
      out_valid_d = out_valid_q;
      scan_idx_d  = scan_idx_q;
      div_d       = div_q;
      cnt_d       = cnt_q;

      if (!en) begin
         state_d     = IDLE;
         out_d       = ONEHOT_IDLE;
         out_valid_d = 1'b0;
         scan_idx_d  = '0;
         div_d       = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  out_d       = dec_oh;
                  out_valid_d = 1'b1;
                  cnt_d       = cnt_q + CNT_W'(1);
                  state_d     = HOLD;
               end else if (scan) begin
                  out_d      = ONEHOT_FIRST;
                  scan_idx_d = '0;
                  div_d      = '0;
                  state_d    = SCAN;
               end else begin
                  out_d = ONEHOT_IDLE;
               end
            end
            HOLD: begin
               if (bus.out_ack) begin
                  if (accept) begin
                     out_d = dec_oh;
                     cnt_d = cnt_q + CNT_W'(1);
                  end else begin
                     out_d       = ONEHOT_IDLE;
                     out_valid_d = 1'b0;
                     state_d     = IDLE;
                  end
               end
            end
            SCAN: begin
               out_valid_d = 1'b0;
               if (!scan) begin
                  out_d      = ONEHOT_IDLE;
                  scan_idx_d = '0;
                  div_d      = '0;
                  state_d    = IDLE;
               end else if (div_q == DIV_LAST) begin
                  div_d      = '0;
                  scan_idx_d = scan_idx_q + 3'd1;
                  out_d      = rotl1(out_q);
               end else begin
                  div_d = div_q + 8'd1;
               end
            end
            default: begin
               state_d     = IDLE;
               out_d       = ONEHOT_IDLE;
               out_valid_d = 1'b0;
               scan_idx_d  = '0;
               div_d       = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         out_q       <= ONEHOT_IDLE;
         out_valid_q <= 1'b0;
         scan_idx_q  <= '0;
         div_q       <= '0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
         scan_idx_q  <= scan_idx_d;
         div_q       <= div_d;
         cnt_q       <= cnt_d;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out       = out_q;
   assign bus.out_valid = out_valid_q;
   assign scan_idx      = scan_idx_q;
   assign xfer_cnt      = cnt_q;

endmodule

// File: tb/tb_decod38_seq.sv
// Scoreboard bench for decod38_seq: dut_a (SCAN_DIV=4, CNT_W=8) and dut_b (SCAN_DIV=1, CNT_W=2).
module tb_decod38_seq;
   import decod38_seq_pkg::*;

   typedef struct packed {
      logic [7:0] out;
      logic [7:0] cnt;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst, en, scan_a, scan_b;
   logic [2:0] scan_idx_a, scan_idx_b;
   logic [7:0] xfer_a;
   logic [1:0] xfer_b;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;
   exp_t        sbq[$];
   logic [7:0]  exp_cnt = 8'd0;

   decod38_seq_if ifa ();
   decod38_seq_if ifb ();

   assign ifb.in       = ifa.in;
   assign ifb.in_valid = ifa.in_valid;
   assign ifb.out_ack  = ifa.out_ack;

   decod38_seq #(.SCAN_DIV(4), .CNT_W(8)) dut_a (
      .clk(clk), .rst(rst), .en(en), .scan(scan_a), .bus(ifa),
      .scan_idx(scan_idx_a), .xfer_cnt(xfer_a)
   );

   decod38_seq #(.SCAN_DIV(1), .CNT_W(2)) dut_b (
      .clk(clk), .rst(rst), .en(en), .scan(scan_b), .bus(ifb),
      .scan_idx(scan_idx_b), .xfer_cnt(xfer_b)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      @(negedge clk);
   endtask

   task automatic push_exp(input logic [2:0] code);
      exp_t e;
      exp_cnt = exp_cnt + 8'd1;
      e.out   = 8'h01 << code;
      e.cnt   = exp_cnt;
      sbq.push_back(e);
   endtask

   // Monitor: every consumed result (out_valid & out_ack) is matched against the queue.
   always @(negedge clk) begin
      if (!rst && ifa.out_valid && ifa.out_ack) begin
         if (sbq.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL sb_empty: got out=%0h expected no result", ifa.out);
         end else begin
            exp_t e;
            e = sbq.pop_front();
            check("sb_out_a", 32'(ifa.out), 32'(e.out));
            check("sb_cnt_a", 32'(xfer_a), 32'(e.cnt));
            check("sb_out_b", 32'(ifb.out), 32'(e.out));
            check("sb_vld_b", 32'(ifb.out_valid), 32'd1);
            check("sb_cnt_b", 32'(xfer_b), 32'(e.cnt[1:0]));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0] oh;
      rst = 1'b1; en = 1'b0; scan_a = 1'b0; scan_b = 1'b0;
      ifa.in = 3'd5; ifa.in_valid = 1'b1; ifa.out_ack = 1'b0;

      // Reset held with a valid code presented
      step(); step();
      settle();
      check("rst_out", 32'(ifa.out), 32'h00);
      check("rst_vld", 32'(ifa.out_valid), 32'd0);
      check("rst_cnt", 32'(xfer_a), 32'd0);
      check("rst_rdy_a", 32'(ifa.in_ready), 32'd0);
      check("rst_rdy_b", 32'(ifb.in_ready), 32'd0);
      step();
      rst = 1'b0;
      step();
      settle();
      check("en0_out", 32'(ifa.out), 32'h00);
      check("en0_vld", 32'(ifa.out_valid), 32'd0);
      check("en0_cnt", 32'(xfer_a), 32'd0);
      check("en0_rdy", 32'(ifa.in_ready), 32'd0);

      // Single decode of 5, held without ack
      step();
      en = 1'b1; ifa.in = 3'd5; ifa.in_valid = 1'b1;
      push_exp(3'd5);
      settle();
      check("idle_rdy", 32'(ifa.in_ready), 32'd1);
      step();
      ifa.in_valid = 1'b0; ifa.in = 3'd2;
      settle();
      check("dec5_out", 32'(ifa.out), 32'h20);
      check("dec5_vld", 32'(ifa.out_valid), 32'd1);
      check("dec5_cnt", 32'(xfer_a), 32'd1);
      for (int i = 0; i < 5; i++) begin
         step();
         settle();
         check("hold_out", 32'(ifa.out), 32'h20);
         check("hold_vld", 32'(ifa.out_valid), 32'd1);
         check("hold_rdy", 32'(ifa.in_ready), 32'd0);
      end

      // Back-to-back: ack with a same-cycle accept of code 0
      step();
      ifa.out_ack = 1'b1; ifa.in_valid = 1'b1; ifa.in = 3'd0;
      push_exp(3'd0);
      settle();
      check("b2b_rdy", 32'(ifa.in_ready), 32'd1);
      step();
      ifa.out_ack = 1'b0; ifa.in_valid = 1'b0;
      settle();
      check("b2b_out", 32'(ifa.out), 32'h01);
      check("b2b_vld", 32'(ifa.out_valid), 32'd1);
      check("b2b_cnt", 32'(xfer_a), 32'd2);
      step();
      ifa.out_ack = 1'b1;
      settle();
      step();
      ifa.out_ack = 1'b0;
      settle();
      check("ack_out", 32'(ifa.out), 32'h00);
      check("ack_vld", 32'(ifa.out_valid), 32'd0);

      // All eight codes with immediate ack
      for (int k = 0; k < 8; k++) begin
         step();
         ifa.in = 3'(k); ifa.in_valid = 1'b1;
         push_exp(3'(k));
         step();
         ifa.in_valid = 1'b0; ifa.out_ack = 1'b1;
         settle();
         step();
         ifa.out_ack = 1'b0;
      end
      settle();
      check("all_cnt_a", 32'(xfer_a), 32'd10);
      check("all_cnt_b", 32'(xfer_b), 32'd2);
      check("all_out", 32'(ifa.out), 32'h00);

      // Scan on dut_a, SCAN_DIV=4: 32 cycles per full walk
      step();
      scan_a = 1'b1;
      step();
      for (int j = 0; j <= 32; j++) begin
         settle();
         oh = 8'h01 << ((j / 4) % 8);
         check("scan_out", 32'(ifa.out), 32'(oh));
         check("scan_idx", 32'(scan_idx_a), 32'((j / 4) % 8));
         check("scan_vld", 32'(ifa.out_valid), 32'd0);
         check("scan_rdy", 32'(ifa.in_ready), 32'd0);
         step();
      end
      scan_a = 1'b0;
      step();
      settle();
      check("scan_off_out", 32'(ifa.out), 32'h00);
      check("scan_off_idx", 32'(scan_idx_a), 32'd0);

      // Enable dropped mid-scan at 8'h10
      step();
      scan_a = 1'b1;
      step();
      repeat (16) step();
      settle();
      check("abort_pre", 32'(ifa.out), 32'h10);
      step();
      en = 1'b0;
      step();
      settle();
      check("abort_out", 32'(ifa.out), 32'h00);
      check("abort_idx", 32'(scan_idx_a), 32'd0);
      check("abort_cnt", 32'(xfer_a), 32'd10);
      step();
      en = 1'b1; scan_a = 1'b0;
      settle();
      check("abort_idle", 32'(ifa.in_ready), 32'd1);

      // Scan on dut_b, SCAN_DIV=1: advances every cycle
      step();
      scan_b = 1'b1;
      step();
      for (int j = 0; j <= 8; j++) begin
         settle();
         oh = 8'h01 << (j % 8);
         check("scanb_out", 32'(ifb.out), 32'(oh));
         check("scanb_idx", 32'(scan_idx_b), 32'(j % 8));
         step();
      end
      scan_b = 1'b0;
      step();
      settle();
      check("scanb_off", 32'(ifb.out), 32'h00);

      // Reset aborts a held result
      step();
      ifa.in = 3'd7; ifa.in_valid = 1'b1;
      step();
      ifa.in_valid = 1'b0;
      settle();
      check("pre_rst_out", 32'(ifa.out), 32'h80);
      check("pre_rst_vld", 32'(ifa.out_valid), 32'd1);
      step();
      rst = 1'b1;
      step();
      settle();
      check("mid_rst_out", 32'(ifa.out), 32'h00);
      check("mid_rst_vld", 32'(ifa.out_valid), 32'd0);
      check("mid_rst_cnt", 32'(xfer_a), 32'd0);
      check("mid_rst_rdy", 32'(ifa.in_ready), 32'd0);
      step();
      rst = 1'b0;
      step();

      check("sb_drained", 32'(sbq.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/decod38_seq.md
Name: decod38_seq

Overview:
Clocked 3-to-8 one-hot decoder. It is the inverse of the team's 8:3 encoder: it turns a 3-bit code back into an 8-bit one-hot vector.
- Adds a valid/ack handshake with output hold.
- Adds an auto-scan mode that walks the one-hot output through all eight lines, for LED/keypad-column drive.
- Sits downstream of the encoder, or standalone as a line-select/strobe generator.

Parameters:
SCAN_DIV, 4, clock cycles each one-hot position is held in scan mode (legal range 1..255)
CNT_W, 8, width of the accepted-transfer counter

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
en  input  1  global enable; low forces idle and clears outputs
in  input  3  binary code to decode
in_valid  input  1  code on `in` is valid
in_ready  output  1  block can accept a code this cycle
scan  input  1  request auto-scan mode
out  output  8  registered one-hot result (or all-zero)
out_valid  output  1  `out` holds a decoded handshake result
out_ack  input  1  consumer has taken `out`
scan_idx  output  3  current scan position (binary)
xfer_cnt  output  CNT_W  count of accepted codes, wraps

Behaviour:
- Clock, reset and enable
  - Single clock `clk`; `rst` is synchronous, active-high, sampled on the rising edge.
  - Reset values: `out`=8'h00, `out_valid`=0, `scan_idx`=0, `xfer_cnt`=0, internal divider=0, state=IDLE. `in_ready` is combinational and is therefore 0 while `rst`=1.
  - `en`=0 (not in reset): the next edge forces state=IDLE, `out`=8'h00, `out_valid`=0, `scan_idx`=0, divider=0. `xfer_cnt` is held.
  - `in_ready`=0 while `en`=0.
- States: IDLE, HOLD, SCAN.
- `in_ready` is combinational: `en` & (state==IDLE & !scan | state==HOLD & out_ack).
- Accept = `in_valid` & `in_ready`.
- IDLE
  - On accept:
    - next edge: `out` = 8'b1 << `in`, `out_valid`=1, `xfer_cnt`+1, state → HOLD.
    - Latency is 1 cycle from accept to `out_valid`.
  - Else if `scan` & `en`: state → SCAN, `out`=8'h01, `scan_idx`=0, divider=0.
  - Else `out` stays 8'h00.
- HOLD
  - `out` and `out_valid` are stable until `out_ack`=1.
  - `out_ack` with a same-cycle accept (back-to-back): `out` loads the new code, `out_valid` stays 1, `xfer_cnt`+1, state remains HOLD.
  - `out_ack` without accept: `out`=8'h00, `out_valid`=0, state → IDLE.
  - `scan` is ignored in HOLD.
  - `in` changing while not accepted has no effect.
- SCAN
  - `out_valid`=0 throughout; `in_ready`=0.
  - Divider counts 0..SCAN_DIV-1. When it reaches SCAN_DIV-1:
    - divider → 0;
    - `scan_idx` increments mod 8;
    - `out` rotates left one bit; 8'h80 wraps to 8'h01.
  - Invariant: `out` == 8'b1 << `scan_idx`.
  - SCAN_DIV=1: `out` advances every cycle.
  - `scan`=0: next edge `out`=8'h00, `scan_idx`=0, state → IDLE.
  - `in_valid` is ignored in SCAN.
- Counter: `xfer_cnt` wraps 2^CNT_W-1 → 0 silently.
- Boundaries
  - `rst` has priority over `en`; `en` has priority over all handshake and scan logic.
  - `rst` asserted mid-HOLD or mid-SCAN aborts immediately; no output glitch beyond the reset value.
  - `in`=3'b000 decodes to 8'h01. `out`=8'h00 only ever means "no result".

Decomposition:
- Shared package holds:
  - state encoding constants (IDLE=2'd0, HOLD=2'd1, SCAN=2'd2);
  - ONEHOT_IDLE=8'h00.
- One natural sub-module: `decod38_comb`. Purely combinational, 3-bit code + enable → 8-bit one-hot. Reused for the IDLE/HOLD load path; scan uses the rotate.
- FSM, divider and counter stay in the top.

Test Plan:
1. Reset/enable:
   - hold `rst`=1 two cycles with `in_valid`=1, `in`=5 → `out`=00, `out_valid`=0, `xfer_cnt`=0, `in_ready`=0.
   - release `rst` with `en`=0 → same values, `in_ready`=0.
2. Single decode:
   - `en`=1, `in`=3'd5, `in_valid`=1 for one cycle → next edge `out`=8'h20, `out_valid`=1, `xfer_cnt`=1.
   - `out` holds 8'h20 for 5 cycles without ack.
   - `out_ack`=1 → next edge `out`=00, `out_valid`=0.
3. Back-to-back:
   - in HOLD with `out`=8'h20, drive `out_ack`=1, `in_valid`=1, `in`=0 → `out`=8'h01, `out_valid` stays 1, `xfer_cnt`=2.
4. All codes:
   - decode `in`=0..7 sequentially with immediate ack → outputs 01,02,04,08,10,20,40,80; `xfer_cnt`=8.
5. Scan:
   - SCAN_DIV=4, `scan`=1 from IDLE → `out`=01 for 4 cycles, then 02, … 80, then wraps to 01 after 32 cycles; `scan_idx` tracks 0..7,0.
   - drop `scan` → `out`=00 next edge.
6. Abort and wrap:
   - drop `en` mid-SCAN at `out`=8'h10 → next edge `out`=00, state IDLE.
   - CNT_W=2, 5 accepts → `xfer_cnt`=1.
